uart_tx: RTL and testbench

UART transmitter for the Atlys board: the outbound counterpart to the receive path feeding `ClockBaseTop`. Accepts bytes over a valid/ready handshake into an 8-entry FIFO and serialises them as 8N1 frames, LSB first, at 57600 baud from the 100 MHz board clock. It lets the design echo or report message bytes, including 0x7E-delimited frames, back to the host over the same serial link the receiver listens on.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 31 +++
 rtl/uart_tx_fifo.sv | 75 +++++++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions for the transmit path and for the receive path
//   feeding ClockBaseTop.
//   Contents:
//     CLKS_PER_BIT_57600 - clocks per bit at 57600 baud from a 100 MHz clock
//     FRAME_BITS         - bits per 8N1 frame (start + 8 data + stop)
//     FRAME_FLAG         - message frame delimiter byte
//     tx_state_t         - transmitter FSM states
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_57600 = 1736;
   localparam int unsigned FRAME_BITS         = 10;
   localparam logic [7:0]  FRAME_FLAG         = 8'h7E;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// ----------------------------------------------------------------------------
// uart_tx_if
//   Byte handshake into the UART transmitter. A byte moves on a rising clock
//   edge where tx_valid && tx_ready.
//   Signals:
//     tx_data  - byte to transmit (source -> transmitter)
//     tx_valid - tx_data is valid this cycle (source -> transmitter)
//     tx_ready - transmitter can accept a byte (transmitter -> source)
//   Modports:
//     master - byte source
//     slave  - transmitter
// ----------------------------------------------------------------------------
interface uart_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
//   Synchronous byte FIFO, depth 2**FIFO_AW, first-word fall-through read
//   (dataOut always shows the head entry). Usable on both UART directions.
//   Ports:
//     clk     - clock, rising edge
//     rstN    - asynchronous active-low reset, clears pointers and count
//     push    - write dataIn (ignored while full)
//     pop     - discard head entry (ignored while empty)
//     dataIn  - byte to write
//     dataOut - head entry
//     full    - count == depth
//     empty   - count == 0
//     count   - entries held, 0..depth
// ----------------------------------------------------------------------------
module byte_fifo #(
   parameter int unsigned FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               push,
   input  logic               pop,
   input  logic [7:0]         dataIn,
   output logic [7:0]         dataOut,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   count
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;

   logic [7:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]  wrPtr;
   logic [FIFO_AW-1:0]  rdPtr;
   logic [FIFO_AW:0]    countQ;
   logic                doPush;
   logic                doPop;

   // full is taken from the registered count, so a pop while full does not
   // reopen the input until the following cycle.
   assign full    = (countQ == (FIFO_AW + 1)'(DEPTH));
   assign empty   = (countQ == '0);
   assign count   = countQ;
   assign dataOut = mem[rdPtr];

   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= dataIn;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         countQ <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + FIFO_AW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + FIFO_AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   countQ <= countQ + (FIFO_AW + 1)'(1);
            2'b01:   countQ <= countQ - (FIFO_AW + 1)'(1);
            default: countQ <= countQ;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//   8N1 UART transmitter, LSB first. Bytes arrive over the uart_tx_if
//   handshake into a byte_fifo and are serialised back to back with no idle
//   gap while the FIFO holds data.
//   Parameters:
//     CLKS_PER_BIT - clock cycles per serial bit (1736 = 100 MHz / 57600)
//     FIFO_AW      - FIFO address width, depth 2**FIFO_AW
//   Ports:
//     CLK        - system clock, rising edge
//     reset      - asynchronous active-low reset; aborts any frame in flight
//     txIf       - byte handshake (slave side)
//     tx_busy    - frame on the line or bytes queued
//     fifo_count - bytes currently queued
//     ct_UartTx  - serial line, idle high, driven from a flop
// ----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_57600,
   parameter int unsigned FIFO_AW      = 3
) (
   input  logic             CLK,
   input  logic             reset,
   uart_tx_if.slave         txIf,
   output logic             tx_busy,
   output logic [FIFO_AW:0] fifo_count,
   output logic             ct_UartTx
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t        state;
   tx_state_t        stateNext;
   logic [CW-1:0]    baudCnt;
   logic [2:0]       bitIdx;
   logic [7:0]       shiftReg;
   logic             lineQ;
   logic             busyQ;
   logic             lineNext;
   logic             busyNext;
   logic             bitDone;
   logic             popHead;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [7:0]       fifoHead;

   byte_fifo #(
      .FIFO_AW (FIFO_AW)
   ) uFifo (
      .clk     (CLK),
      .rstN    (reset),
      .push    (txIf.tx_valid),
      .pop     (popHead),
      .dataIn  (txIf.tx_data),
      .dataOut (fifoHead),
      .full    (fifoFull),
      .empty   (fifoEmpty),
      .count   (fifo_count)
   );

   assign txIf.tx_ready = !fifoFull;
   assign bitDone       = (baudCnt == BAUD_LAST);
   assign ct_UartTx     = lineQ;
   assign tx_busy       = busyQ;

   // ---------------------------------------------------------------- state
   // Line and busy are registered from the current state, so both lag the
   // FSM by one cycle: a pop at edge k+1 shows the start bit at edge k+2,
   // and busy drops together with the end of the last stop bit.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         lineQ    <= 1'b1;
         busyQ    <= 1'b0;
      end else begin
         state <= stateNext;

         // Held at zero while idle so every frame starts from a full bit.
         if (state == IDLE || bitDone) begin
            baudCnt <= '0;
         end else begin
            baudCnt <= baudCnt + CW'(1);
         end

         if (state != DATA) begin
            bitIdx <= '0;
         end else if (bitDone) begin
            bitIdx <= bitIdx + 3'd1;
         end

         if (popHead) begin
            shiftReg <= fifoHead;
         end else if (state == DATA && bitDone) begin
            shiftReg <= {1'b0, shiftReg[7:1]};
         end

         lineQ <= lineNext;
         busyQ <= busyNext;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      stateNext = state;
      popHead   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               popHead   = 1'b1;
               stateNext = START;
            end
         end
         START: begin
            if (bitDone) begin
               stateNext = DATA;
            end
         end
         DATA: begin
            if (bitDone && bitIdx == 3'd7) begin
               stateNext = STOP;
            end
         end
         STOP: begin
            if (bitDone) begin
               // Chaining straight into START keeps queued frames contiguous.
               if (!fifoEmpty) begin
                  popHead   = 1'b1;
                  stateNext = START;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      lineNext = 1'b1;
      case (state)
         IDLE:    lineNext = 1'b1;
         START:   lineNext = 1'b0;
         DATA:    lineNext = shiftReg[0];
         STOP:    lineNext = 1'b1;
         default: lineNext = 1'b1;
      endcase
      busyNext = (state != IDLE) || !fifoEmpty;
   end

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx with a short bit time. Accepted bytes are queued as
//   expected frames; a line monitor decodes every frame and compares it.
// ----------------------------------------------------------------------------
module tb_uart_tx;
   import uart_pkg::*;

   localparam int unsigned CPB   = 16;
   localparam int unsigned FAW   = 3;
   localparam int unsigned FRAME = FRAME_BITS * CPB;
   localparam int          BUDGET = 20 * FRAME;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             txBusy;
   logic [FAW:0]     fifoCount;
   logic             line;

   uart_tx_if txBus ();

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (FAW)
   ) dut (
      .CLK        (clk),
      .reset      (rstN),
      .txIf       (txBus),
      .tx_busy    (txBusy),
      .fifo_count (fifoCount),
      .ct_UartTx  (line)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         lastAccept = -1;
   logic [7:0] expQ [$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard input: every accepted byte becomes an expected frame.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rstN && txBus.tx_valid && txBus.tx_ready) begin
         expQ.push_back(txBus.tx_data);
         lastAccept = cyc;
      end
   end

   // Line monitor
   logic sample [FRAME];
   bit   inFrame = 1'b0;
   bit   contigMode = 1'b0;
   int   idx = 0;
   int   curStart = -1;
   int   lastEnd = -1;
   int   framesSeen = 0;

   task automatic endFrame();
      bit         shapeOk;
      logic [7:0] got;
      logic       mid;
      shapeOk = 1'b1;
      got = '0;
      for (int b = 0; b < int'(FRAME_BITS); b++) begin
         mid = sample[b * CPB + CPB / 2];
         for (int i = 0; i < int'(CPB); i++) begin
            if (sample[b * CPB + i] !== mid) shapeOk = 1'b0;
         end
         if (b >= 1 && b <= 8) got[b - 1] = mid;
      end
      chk("frameShape", int'(shapeOk), 1);
      chk("stopBit", int'(sample[9 * CPB + CPB / 2]), 1);
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpectedFrame actual=%0h required=none", got);
      end else begin
         chk("frameByte", int'(got), int'(expQ.pop_front()));
      end
   endtask

   always @(negedge clk) begin
      if (!rstN) begin
         inFrame = 1'b0;
         lastEnd = -1;
      end else if (!inFrame) begin
         if (line == 1'b0) begin
            inFrame = 1'b1;
            sample[0] = line;
            idx = 1;
            curStart = cyc;
            if (contigMode && lastEnd >= 0) chk("frameGap", cyc - lastEnd - 1, 0);
         end
      end else begin
         sample[idx] = line;
         idx++;
         if (idx == int'(FRAME)) begin
            inFrame = 1'b0;
            lastEnd = cyc;
            framesSeen++;
            endFrame();
         end
      end
   end

   // Stimulus acts just after the falling edge, after the monitor has sampled.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pushByte(input logic [7:0] b);
      int n;
      txBus.tx_data  = b;
      txBus.tx_valid = 1'b1;
      n = 0;
      while (!txBus.tx_ready && n < BUDGET) begin
         step();
         n++;
      end
      chk("pushWait", int'(n < BUDGET), 1);
      step();
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((expQ.size() != 0 || txBusy || inFrame) && n < BUDGET) begin
         step();
         n++;
      end
      chk(name, int'(n < BUDGET), 1);
   endtask

   logic [7:0] burst [9]    = '{8'h7E, 8'h08, 8'hC0, 8'hF0, 8'hFE, 8'hFE, 8'hFC, 8'hFF, 8'h01};
   logic [7:0] loopSet [5]  = '{8'h7E, 8'h08, 8'h0F, 8'hF0, 8'h00};
   logic [7:0] abortSet [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};

   initial begin
      int n;
      int popEdge;
      int seen;
      bit idleOk;

      txBus.tx_valid = 1'b0;
      txBus.tx_data  = '0;
      repeat (3) step();
      chk("rstLine", int'(line), 1);
      chk("rstReady", int'(txBus.tx_ready), 1);
      chk("rstBusy", int'(txBusy), 0);
      chk("rstCount", int'(fifoCount), 0);
      rstN = 1'b1;
      step();

      // Single byte 0xF4
      pushByte(8'hF4);
      txBus.tx_valid = 1'b0;
      chk("countAfterPush", int'(fifoCount), 1);
      step();
      chk("countAfterPop", int'(fifoCount), 0);
      chk("busyAfterPop", int'(txBusy), 1);
      n = 0;
      while (!inFrame && n < BUDGET) begin step(); n++; end
      chk("startSeen", int'(n < BUDGET), 1);
      chk("startLatency", curStart - lastAccept, 2);
      n = 0;
      while (txBusy && n < BUDGET) begin step(); n++; end
      chk("busyFall", int'(n < BUDGET), 1);
      chk("busyDrop", cyc - curStart, int'(FRAME));
      chk("framesAfterF4", framesSeen, 1);

      // Burst of nine with valid held high
      foreach (burst[i]) pushByte(burst[i]);
      chk("burstFull", int'(fifoCount), 8);
      chk("readyLowFull", int'(txBus.tx_ready), 0);
      chk("burstAccepted", expQ.size(), 9);
      contigMode = 1'b1;

      // Handshake violation while full: must be dropped
      txBus.tx_data  = 8'h55;
      txBus.tx_valid = 1'b1;
      step();
      txBus.tx_valid = 1'b0;
      chk("fullPushCount", int'(fifoCount), 8);

      n = 0;
      while (fifoCount == 8 && n < BUDGET) begin
         chk("readyWhileFull", int'(txBus.tx_ready), 0);
         step();
         n++;
      end
      chk("countAfterFullPop", int'(fifoCount), 7);
      chk("readyAfterFullPop", int'(txBus.tx_ready), 1);

      // Push exactly on a pop edge while three bytes are queued
      n = 0;
      while (fifoCount != 3 && n < BUDGET) begin step(); n++; end
      chk("reachCount3", int'(n < BUDGET), 1);
      popEdge = cyc + int'(FRAME);
      while (cyc < popEdge - 1) step();
      txBus.tx_data  = 8'h3C;
      txBus.tx_valid = 1'b1;
      step();
      txBus.tx_valid = 1'b0;
      chk("pushPopEdge", lastAccept, popEdge);
      chk("pushPopCount", int'(fifoCount), 3);
      waitDrain("burstDrain");
      contigMode = 1'b0;
      chk("framesAfterBurst", framesSeen, 11);

      // Reset in the middle of a data bit with three bytes queued
      foreach (abortSet[i]) pushByte(abortSet[i]);
      txBus.tx_valid = 1'b0;
      chk("abortQueued", int'(fifoCount), 3);
      n = 0;
      while (!inFrame && n < BUDGET) begin step(); n++; end
      repeat (3 * CPB) step();
      seen = framesSeen;
      rstN = 1'b0;
      #1;
      chk("abortLine", int'(line), 1);
      chk("abortCount", int'(fifoCount), 0);
      chk("abortBusy", int'(txBusy), 0);
      chk("abortReady", int'(txBus.tx_ready), 1);
      expQ.delete();
      repeat (3) step();
      rstN = 1'b1;
      idleOk = 1'b1;
      repeat (4 * FRAME) begin
         step();
         if (line !== 1'b1 || fifoCount != 0) idleOk = 1'b0;
      end
      chk("idleAfterAbort", int'(idleOk), 1);
      chk("noFrameAfterAbort", framesSeen, seen);

      // Message bytes as the receive path would see them
      foreach (loopSet[i]) pushByte(loopSet[i]);
      txBus.tx_valid = 1'b0;
      waitDrain("loopDrain");
      chk("loopFrames", framesSeen, seen + 5);
      chk("queueEmpty", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
